// File: rtl/bcd_counter_scan.sv
`default_nettype none
// ============================================================================
// Module  : bcd_counter_scan
// Brief   : Debounced push-button stepping a multi-digit BCD up/down counter,
//           shown on a time-multiplexed 7-segment display.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_counter_scan #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SCAN_DIV        = 1024,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit BLANK_LZ        = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                but_input,
  input  logic                up_dn,
  input  logic                clr,
  output logic [4*DIGITS-1:0] bcd,
  output logic                wrap,
  output logic [DIGITS-1:0]   an,
  output logic [0:6]          seg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     C_DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]     C_SCAN_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     C_IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] C_AN_DIG0   = DIGITS'(1);
  localparam logic [0:6]        C_SEG_ZERO  = 7'b1111110;
  localparam logic [DIGITS-1:0] C_AN_RST    = ACTIVE_LOW ? ~C_AN_DIG0 : C_AN_DIG0;
  localparam logic [0:6]        C_SEG_RST   = ACTIVE_LOW ? ~C_SEG_ZERO : C_SEG_ZERO;

  // Segment order is a..g, segment a in bit 0 of the [0:6] vector.
  function automatic logic [0:6] seg_decode(input logic [3:0] d);
    logic [0:6] p;
    case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // --------------------------------------------------------------------------
  // Input conditioning: synchroniser, debounce, rising-edge detect
  // --------------------------------------------------------------------------
  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic          deb_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_step;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_DEB_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= but_input;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign w_step = deb_q & ~deb_dly_q;

  // --------------------------------------------------------------------------
  // Cascaded BCD up/down counter
  // --------------------------------------------------------------------------
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_d;
  logic                wrap_q;
  logic                wrap_d;
  logic                w_carry;
  logic [3:0]          w_digit;

  always_comb begin
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    w_carry = 1'b1;
    w_digit = '0;
    if (clr) begin
      bcd_d = '0;
    end else if (w_step) begin
      // The carry/borrow ripples upward; surviving past the top digit is a wrap.
      for (int k = 0; k < DIGITS; k++) begin
        w_digit = bcd_q[4*k +: 4];
        if (w_carry) begin
          if (up_dn) begin
            if (w_digit >= 4'd9) begin
              w_digit = 4'd0;
            end else begin
              w_digit = w_digit + 4'd1;
              w_carry = 1'b0;
            end
          end else begin
            if (w_digit == 4'd0) begin
              w_digit = 4'd9;
            end else begin
              w_digit = w_digit - 4'd1;
              w_carry = 1'b0;
            end
          end
        end
        bcd_d[4*k +: 4] = w_digit;
      end
      wrap_d = w_carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  logic [PW-1:0]     pre_q;
  logic [PW-1:0]     pre_d;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [3:0]        w_digits [DIGITS];
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;
  logic [DIGITS-1:0] w_an_raw;
  logic [0:6]        w_seg_raw;
  logic [DIGITS-1:0] an_d;
  logic [0:6]        seg_d;
  logic [DIGITS-1:0] an_q;
  logic [0:6]        seg_q;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign w_digits[k] = bcd_q[4*k +: 4];
    end
  endgenerate

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == C_SCAN_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and everything above it is zero.
  always_comb begin
    w_zero_above = 1'b1;
    w_blank      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (w_digits[k] == 4'd0);
      w_blank[k]   = w_zero_above && (k != 0);
    end
  end

  always_comb begin
    w_an_raw        = '0;
    w_an_raw[idx_q] = 1'b1;
    w_seg_raw       = seg_decode(w_digits[idx_q]);
    if (BLANK_LZ && w_blank[idx_q]) begin
      w_seg_raw = '0;
    end
    an_d  = ACTIVE_LOW ? ~w_an_raw : w_an_raw;
    seg_d = ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  end

  // an and seg share one register stage so the pair always matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= C_AN_RST;
      seg_q <= C_SEG_RST;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_counter_scan
// Brief   : Self-checking bench for bcd_counter_scan (4 digits, short timers).
// Rev     : 1.0  initial release
// ============================================================================
module tb_bcd_counter_scan;

  localparam int DEB = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        but_input = 1'b0;
  logic        up_dn     = 1'b1;
  logic        clr       = 1'b0;
  logic [15:0] bcd,    bcd_nb;
  logic        wrap,   wrap_nb;
  logic [3:0]  an,     an_nb;
  logic [0:6]  seg,    seg_nb;

  int n_cmp      = 0;
  int n_bad      = 0;
  int wrap_total = 0;
  int model      = 0;

  bcd_counter_scan #(.DIGITS(4), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(4),
                     .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .but_input(but_input), .up_dn(up_dn), .clr(clr),
    .bcd(bcd), .wrap(wrap), .an(an), .seg(seg));

  bcd_counter_scan #(.DIGITS(4), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(4),
                     .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .but_input(but_input), .up_dn(up_dn), .clr(clr),
    .bcd(bcd_nb), .wrap(wrap_nb), .an(an_nb), .seg(seg_nb));

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap === 1'b1) wrap_total++;

  typedef struct {
    logic        clr_op;
    logic        dir;
    logic [15:0] exp_bcd;
    int          exp_wrap;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic press(input logic dir, input int hold, input int rel);
    up_dn     = dir;
    but_input = 1'b1;
    repeat (hold) tick();
    but_input = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  logic [6:0] exp_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg  [4] = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
  logic [6:0] exp_segn [4] = '{7'b0010010, 7'b1001100, 7'b0000001, 7'b0000001};

  initial begin
    int w0;
    int old;
    int r;
    logic dir;
    logic [3:0] prev_an;
    logic found;

    tbl[0] = '{1'b0, 1'b1, 16'h0001, 0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 0};
    tbl[2] = '{1'b0, 1'b0, 16'h9999, 1};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 1};
    tbl[4] = '{1'b0, 1'b0, 16'h9999, 1};
    tbl[5] = '{1'b0, 1'b0, 16'h9998, 0};
    tbl[6] = '{1'b0, 1'b1, 16'h9999, 0};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 0};
    tbl[8] = '{1'b0, 1'b1, 16'h0001, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset bcd", 32'(bcd), 32'h0);
    check("reset wrap", 32'(wrap), 32'h0);
    check("reset an", 32'(an), 32'hE);
    check("reset seg", 32'(seg), 32'h01);

    // Press held from before edge 1: count moves at edge DEB+3 only
    reset     = 1'b0;
    but_input = 1'b1;
    w0        = wrap_total;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("latency edge %0d", k), 32'(bcd), (k >= DEB + 3) ? 32'h1 : 32'h0);
    end
    but_input = 1'b0;
    repeat (DEB + 4) tick();
    check("latency single step", 32'(bcd), 32'h1);
    check("latency wrap", 32'(wrap_total - w0), 32'h0);

    // clr in the step cycle wins
    w0        = wrap_total;
    but_input = 1'b1;
    repeat (DEB + 2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr vs step", 32'(bcd), 32'h0);
    repeat (4) tick();
    but_input = 1'b0;
    repeat (DEB + 4) tick();
    check("clr vs step hold", 32'(bcd), 32'h0);
    check("clr vs step wrap", 32'(wrap_total - w0), 32'h0);

    // Table of single operations from zero
    for (int i = 0; i < 9; i++) begin
      w0 = wrap_total;
      if (tbl[i].clr_op) clr_pulse();
      else press(tbl[i].dir, DEB + 3, DEB + 4);
      check($sformatf("tbl[%0d] bcd", i), 32'(bcd), 32'(tbl[i].exp_bcd));
      check($sformatf("tbl[%0d] wrap", i), 32'(wrap_total - w0), 32'(tbl[i].exp_wrap));
    end

    // Bounce: 2-cycle toggles never reach the debounce threshold
    up_dn = 1'b1;
    for (int t = 0; t < 10; t++) begin
      but_input = ~but_input;
      repeat (2) tick();
    end
    but_input = 1'b0;
    repeat (DEB + 4) tick();
    check("bounce ignored", 32'(bcd), 32'h0001);
    press(1'b1, 10, DEB + 4);
    check("clean press after bounce", 32'(bcd), 32'h0002);

    // Carry across digits: 0999 -> 1000 -> 0999
    clr_pulse();
    for (int i = 0; i < 999; i++) press(1'b1, DEB + 3, DEB + 4);
    check("count to 0999", 32'(bcd), 32'h0999);
    w0 = wrap_total;
    press(1'b1, DEB + 3, DEB + 4);
    check("carry 0999->1000", 32'(bcd), 32'h1000);
    press(1'b0, DEB + 3, DEB + 4);
    check("borrow 1000->0999", 32'(bcd), 32'h0999);
    check("carry/borrow wrap", 32'(wrap_total - w0), 32'h0);

    // Random operations against an integer model
    model = 999;
    for (int i = 0; i < 120; i++) begin
      r  = int'($urandom_range(0, 9));
      w0 = wrap_total;
      old = model;
      if (r == 0) begin
        clr_pulse();
        model = 0;
        check("rand clr", 32'(bcd), 32'(to_bcd(model)));
      end else if (r <= 2) begin
        but_input = 1'b1;
        repeat (int'($urandom_range(1, DEB - 1))) tick();
        but_input = 1'b0;
        repeat (DEB + 4) tick();
        check("rand glitch", 32'(bcd), 32'(to_bcd(model)));
        check("rand glitch wrap", 32'(wrap_total - w0), 32'h0);
      end else begin
        dir = 1'($urandom_range(0, 1));
        press(dir, int'($urandom_range(DEB + 3, DEB + 8)), int'($urandom_range(DEB + 4, DEB + 8)));
        model = dir ? (model + 1) % 10000 : (model + 9999) % 10000;
        check("rand press", 32'(bcd), 32'(to_bcd(model)));
        check("rand press wrap", 32'(wrap_total - w0),
              ((dir && old == 9999) || (!dir && old == 0)) ? 32'h1 : 32'h0);
      end
    end

    // Scan with 0042
    clr_pulse();
    for (int i = 0; i < 42; i++) press(1'b1, DEB + 3, DEB + 4);
    check("scan value", 32'(bcd), 32'h0042);
    check("scan value nb", 32'(bcd_nb), 32'h0042);
    prev_an = an;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    check("scan sync", 32'(found), 32'h1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      check($sformatf("scan an %0d", i), 32'(an), 32'(exp_an[i / 4]));
      check($sformatf("scan seg %0d", i), 32'(seg), 32'(exp_seg[i / 4]));
      check($sformatf("scan an nb %0d", i), 32'(an_nb), 32'(exp_an[i / 4]));
      check($sformatf("scan seg nb %0d", i), 32'(seg_nb), 32'(exp_segn[i / 4]));
    end
    check("scan wrap nb", 32'(wrap_nb), 32'h0);

    // Async reset in the middle of a debounce, button held through release
    but_input = 1'b1;
    up_dn     = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid reset bcd", 32'(bcd), 32'h0);
    check("mid reset wrap", 32'(wrap), 32'h0);
    check("mid reset an", 32'(an), 32'hE);
    check("mid reset seg", 32'(seg), 32'h01);
    @(posedge clk);
    #1;
    reset = 1'b0;
    w0    = wrap_total;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("post reset edge %0d", k), 32'(bcd), (k >= DEB + 3) ? 32'h1 : 32'h0);
    end
    but_input = 1'b0;
    repeat (DEB + 4) tick();
    check("post reset single step", 32'(bcd), 32'h1);
    check("post reset wrap", 32'(wrap_total - w0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
Parametrised, fully synchronous successor to the push-button ripple counter.
- A raw push-button is synchronised, debounced and rising-edge detected.
- Each press steps a multi-digit BCD up/down counter with a cascaded decimal carry.
- The count is shown on a time-multiplexed 7-segment display with optional leading-zero blanking.
- Sits between the board button/switch pins and the on-board seven-segment display.

Parameters:
DIGITS, 4, number of BCD digits and display anodes (1..8)
DEBOUNCE_CYCLES, 1000, consecutive clk cycles a new button level must persist before it is accepted (>=2)
SCAN_DIV, 1024, clk cycles each digit is displayed before the scan advances (>=2)
ACTIVE_LOW, 1, 1: seg/an driven active-low; 0: active-high
BLANK_LZ, 1, 1: blank leading zero digits (digit 0 is never blanked)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
but_input  input  1  raw, bouncy, asynchronous push-button, 1 = pressed
up_dn  input  1  1 = count up, 0 = count down; sampled on the step cycle
clr  input  1  synchronous clear of the count, active-high
bcd  output  4*DIGITS  count value; digit k at bits [4k+3:4k], digit 0 = least significant
wrap  output  1  one-cycle pulse when the count wraps (9..9 -> 0..0 or 0..0 -> 9..9)
an  output  DIGITS  digit enables, one-hot, polarity per ACTIVE_LOW
seg  output  [0:6]  segments a..g of the selected digit, polarity per ACTIVE_LOW

Behaviour:
Reset (async, active-high):
- Clears all state: synchroniser, debounce counter and debounced level (0), bcd = 0, wrap = 0, scan prescaler = 0, digit index = 0.
- Outputs during and immediately after reset: an selects digit 0; seg shows "0".

Input conditioning:
- Two-flop synchroniser s1 -> s2.
- Debounce counter cnt:
  - cleared whenever s2 == deb;
  - otherwise increments;
  - when cnt == DEBOUNCE_CYCLES-1 and s2 != deb, then deb <= s2 and cnt <= 0.
- A level differing from deb for fewer than DEBOUNCE_CYCLES consecutive cycles is ignored.
- step = deb & ~deb_q (combinational, one cycle wide). Release produces no step.

Latency:
- but_input rises before clk edge 1 and is held.
- deb rises at edge DEBOUNCE_CYCLES+2.
- bcd updates at edge DEBOUNCE_CYCLES+3.

Counter (per clk edge, in priority order):
1. clr = 1: bcd <= 0, wrap <= 0. clr wins over a simultaneous step.
2. step && up_dn:
   - digit 0 increments;
   - a digit at 9 becomes 0 and carries into the next digit;
   - all digits 9 -> all 0 with wrap = 1 for that cycle.
3. step && !up_dn:
   - digit 0 decrements;
   - a digit at 0 becomes 9 and borrows from the next digit;
   - all digits 0 -> all 9 with wrap = 1.
4. Otherwise: hold, wrap = 0.
- Invariant: digits are always in 0..9.

Display scan:
- Prescaler counts 0..SCAN_DIV-1.
- On the terminal count, the digit index advances idx -> idx+1, wrapping DIGITS-1 -> 0.
- an asserts bit idx only.
- seg decodes digit idx, standard patterns for 0..9 (0 = abcdef, 1 = bc, ... 9 = abcdfg).
- Blanking, when BLANK_LZ = 1: digit idx (idx > 0) is blanked (all segments off) if it and every higher digit are 0.
- an/seg are registered together: no cycle shows a mismatched digit/segment pair.

Reset mid-operation:
- All state clears immediately.
- A button held through reset deassertion is accepted as a fresh press DEBOUNCE_CYCLES+2 edges later, producing exactly one step.

Test Plan:
- DIGITS=4, DEBOUNCE_CYCLES=4, SCAN_DIV=4. Reset, then hold but_input=1 from before edge 1 -> bcd 0x0000 -> 0x0001 at edge 7; wrap stays 0; exactly one step for the whole hold.
- Bounce: toggle but_input every 2 cycles for 20 cycles, then release -> bcd unchanged; next clean 10-cycle press -> exactly +1.
- Up carry/wrap: starting at 0x0999, press up -> 0x1000. From 0x9999, press up -> 0x0000 with a 1-cycle wrap.
- Down/borrow: 0x1000, up_dn=0, press -> 0x0999. Press at 0x0000 -> 0x9999 with wrap=1.
- clr asserted in the same cycle as step -> bcd 0x0000, wrap 0. Async reset pulsed mid-debounce -> all outputs at reset values within the same time step.
- Scan with bcd 0x0042, ACTIVE_LOW=1:
  - an cycles 1110 -> 1101 -> 1011 -> 0111, each for 4 clks;
  - seg shows "2", "4", blank, blank.
  - With BLANK_LZ=0 it shows "2", "4", "0", "0".
